ychg_record_feeder: RTL and testbench

Upstream stage of the Y-matrix change-integration datapath. Buffers incoming change records (row, col, real, img) in a small FIFO and issues them one at a time to the integration stage. Holds each record stable until the datapath signals completion, or until a watchdog expires. Reports batch completion and per-record status to the controller.

---
 rtl/ychg_pkg.sv | 21 ++
 rtl/ychg_fifo.sv | 66 ++++++
 rtl/ychg_record_feeder.sv | 161 ++++++++++++++++
 tb/tb_ychg_record_feeder.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ychg_pkg.sv
// Shared types for the Y-matrix change-record feeder: default field widths,
// the packed change record and the issue FSM state encoding.
package ychg_pkg;

  localparam int unsigned CHG_ROW_W = 16;
  localparam int unsigned CHG_VAL_W = 24;

  typedef struct packed {
    logic [CHG_ROW_W-1:0] row;
    logic [CHG_ROW_W-1:0] col;
    logic [CHG_VAL_W-1:0] re;
    logic [CHG_VAL_W-1:0] img;
  } chg_rec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/ychg_fifo.sv
// Generic synchronous FIFO of packed records; full is registered, a push
// while full is ignored even if a pop frees a slot in the same cycle.
module ychg_fifo
  import ychg_pkg::*;
#(
  parameter type         T     = chg_rec_t,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [AW:0]     LP_DEPTH = (AW+1)'(DEPTH);

  T                r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_full;
  logic [AW:0]     w_count_nxt;
  logic            w_do_push;
  logic            w_do_pop;

  always_comb begin
    w_do_push   = i_push && !r_full;
    w_do_pop    = i_pop && (r_count != '0);
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LP_DEPTH);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ychg_record_feeder.sv
// Buffers change records and issues them one at a time to the integration stage
// with a done/watchdog handshake. Define YCHG_RANGE_CHECK_EN to discard out-of-range indices.
module ychg_record_feeder
  import ychg_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned ROW_W          = CHG_ROW_W,
  parameter int unsigned VAL_W          = CHG_VAL_W,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MATRIX_DIM     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             chg_push,
  input  logic [ROW_W-1:0] chg_row_in,
  input  logic [ROW_W-1:0] chg_col_in,
  input  logic [VAL_W-1:0] chg_real_in,
  input  logic [VAL_W-1:0] chg_img_in,
  output logic             chg_full,
  input  logic             batch_end,
  output logic [ROW_W-1:0] chg_row,
  output logic [ROW_W-1:0] chg_col,
  output logic [VAL_W-1:0] chg_real,
  output logic [VAL_W-1:0] chg_img,
  output logic             chg_start,
  input  logic             dp_done,
  output logic [15:0]      rec_count,
  output logic             timeout_err,
  output logic             drop_err,
  output logic             batch_done
);

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] col;
    logic [VAL_W-1:0] re;
    logic [VAL_W-1:0] img;
  } rec_t;

  localparam int unsigned      CW         = $clog2(DEPTH) + 1;
  localparam int unsigned      WD_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  LP_WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ROW_W:0]   LP_DIM     = (ROW_W+1)'(MATRIX_DIM);
`ifdef YCHG_RANGE_CHECK_EN
  localparam bit               LP_RANGE_CHK = 1'b1;
`else
  localparam bit               LP_RANGE_CHK = 1'b0;
`endif

  rec_t             w_in_rec;
  rec_t             w_head;
  rec_t             r_rec;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic             w_pop;
  logic             w_idx_bad;
  logic             w_range_bad;
  logic             w_batch_done;
  logic             w_clear;

  state_t           r_state;
  logic [WD_W-1:0]  r_wd;
  logic             r_start;
  logic [15:0]      r_rec_count;
  logic             r_timeout_err;
  logic             r_drop_err;
  logic             r_pending;

  assign w_in_rec = '{chg_row_in, chg_col_in, chg_real_in, chg_img_in};

  ychg_fifo #(
    .T     (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (chg_push),
    .i_data  (w_in_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_pop        = (r_state == IDLE) && !w_empty;
    w_idx_bad    = ({1'b0, w_head.row} >= LP_DIM) || ({1'b0, w_head.col} >= LP_DIM);
    w_range_bad  = LP_RANGE_CHK && w_idx_bad;
    w_batch_done = r_pending && (w_count == '0) && (r_state == IDLE);
    // the first push after a finished batch opens a fresh one
    w_clear      = chg_push && w_batch_done;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_rec         <= '0;
      r_wd          <= '0;
      r_start       <= 1'b0;
      r_rec_count   <= '0;
      r_timeout_err <= 1'b0;
      r_drop_err    <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (chg_push && w_full) r_drop_err <= 1'b1;
      if (w_clear) begin
        r_pending     <= 1'b0;
        r_rec_count   <= '0;
        r_timeout_err <= 1'b0;
        r_drop_err    <= 1'b0;
      end
      if (batch_end) r_pending <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            if (w_range_bad) begin
              r_drop_err <= 1'b1;
            end else begin
              r_rec   <= w_head;
              r_start <= 1'b1;
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_wd    <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (dp_done) begin
            if (r_rec_count != '1) r_rec_count <= r_rec_count + 16'd1;
            r_state <= IDLE;
          end else if (r_wd == LP_WD_LAST) begin
            if (r_rec_count != '1) r_rec_count <= r_rec_count + 16'd1;
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign chg_full    = w_full;
  assign chg_row     = r_rec.row;
  assign chg_col     = r_rec.col;
  assign chg_real    = r_rec.re;
  assign chg_img     = r_rec.img;
  assign chg_start   = r_start;
  assign rec_count   = r_rec_count;
  assign timeout_err = r_timeout_err;
  assign drop_err    = r_drop_err;
  assign batch_done  = w_batch_done;

endmodule

// File: tb/tb_ychg_record_feeder.sv
// Directed bench for ychg_record_feeder: a per-cycle vector table for the basic
// issue/done/batch flow, plus hand sequences for timeout, overflow and reset.
module tb_ychg_record_feeder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned ROW_W = 16;
  localparam int unsigned VAL_W = 24;
  localparam int unsigned TMO   = 64;
  localparam int unsigned DIM   = 16;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [23:0] re;
    logic [23:0] img;
  } rec_t;

  typedef struct {
    int unsigned push_sel;
    logic        dp;
    logic        bend;
    logic        e_start;
    logic [15:0] e_cnt;
    logic        e_bdone;
    int unsigned e_sel;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        chg_push = 1'b0;
  logic [15:0] chg_row_in = '0;
  logic [15:0] chg_col_in = '0;
  logic [23:0] chg_real_in = '0;
  logic [23:0] chg_img_in = '0;
  logic        batch_end = 1'b0;
  logic        dp_done = 1'b0;
  logic        chg_full;
  logic [15:0] chg_row;
  logic [15:0] chg_col;
  logic [23:0] chg_real;
  logic [23:0] chg_img;
  logic        chg_start;
  logic [15:0] rec_count;
  logic        timeout_err;
  logic        drop_err;
  logic        batch_done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ychg_record_feeder #(
    .DEPTH          (DEPTH),
    .ROW_W          (ROW_W),
    .VAL_W          (VAL_W),
    .TIMEOUT_CYCLES (TMO),
    .MATRIX_DIM     (DIM)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .chg_push    (chg_push),
    .chg_row_in  (chg_row_in),
    .chg_col_in  (chg_col_in),
    .chg_real_in (chg_real_in),
    .chg_img_in  (chg_img_in),
    .chg_full    (chg_full),
    .batch_end   (batch_end),
    .chg_row     (chg_row),
    .chg_col     (chg_col),
    .chg_real    (chg_real),
    .chg_img     (chg_img),
    .chg_start   (chg_start),
    .dp_done     (dp_done),
    .rec_count   (rec_count),
    .timeout_err (timeout_err),
    .drop_err    (drop_err),
    .batch_done  (batch_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_v(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk_v(nm, 80'(act), 80'(exp));
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    chk_v(nm, 80'(act), 80'(exp));
  endtask

  task automatic chkn(input string nm, input int unsigned act, input int unsigned exp);
    chk_v(nm, 80'(act), 80'(exp));
  endtask

  task automatic chkrec(input string nm, input rec_t exp);
    rec_t act;
    act = '{chg_row, chg_col, chg_real, chg_img};
    chk_v(nm, act, exp);
  endtask

  task automatic chk_all_zero(input string nm);
    chk1({nm, "_start"}, chg_start, 1'b0);
    chk1({nm, "_full"}, chg_full, 1'b0);
    chkrec({nm, "_data"}, '0);
    chk16({nm, "_cnt"}, rec_count, 16'd0);
    chk1({nm, "_terr"}, timeout_err, 1'b0);
    chk1({nm, "_derr"}, drop_err, 1'b0);
    chk1({nm, "_bdone"}, batch_done, 1'b0);
  endtask

  task automatic set_push(input rec_t r);
    chg_push    = 1'b1;
    chg_row_in  = r.row;
    chg_col_in  = r.col;
    chg_real_in = r.re;
    chg_img_in  = r.img;
  endtask

  task automatic do_reset();
    chg_push  = 1'b0;
    dp_done   = 1'b0;
    batch_end = 1'b0;
    reset     = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_start(input int unsigned lim, output int unsigned n, output bit found);
    n = 0;
    found = 1'b0;
    while (!found && n < lim) begin
      tick();
      n++;
      if (chg_start) found = 1'b1;
    end
  endtask

  task automatic serve_now();
    // called in the ISSUE cycle: complete the record in its first WAIT cycle
    tick();
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
  endtask

  function automatic rec_t mkrec(input int unsigned k);
    rec_t r;
    r.row = 16'(k & 15);
    r.col = 16'((k * 5 + 3) & 15);
    r.re  = 24'(k * 32'h013579 + 32'h100);
    r.img = 24'(32'hABCDEF ^ k);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t        vecs[15];
    rec_t        trecs[3];
    rec_t        rr[3];
    int unsigned n;
    int unsigned k;
    bit          f;

    trecs[0] = '0;
    trecs[1] = '{16'h0000, 16'h0010, 24'h4ebd90, 24'h5c2e27};
    trecs[2] = '{16'h0001, 16'h0002, 24'h000111, 24'hfff222};

    //          push dp    bend  start cnt    bdone sel
    vecs[0]  = '{1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 0};
    vecs[1]  = '{0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1};
    vecs[2]  = '{0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1};
    vecs[3]  = '{0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1};
    vecs[4]  = '{0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1};
    vecs[5]  = '{0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1};
    vecs[6]  = '{0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1};
    vecs[7]  = '{0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 1};
    vecs[8]  = '{0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 1};
    vecs[9]  = '{0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1};
    vecs[10] = '{2, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1};
    vecs[11] = '{0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 2};
    vecs[12] = '{0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 2};
    vecs[13] = '{0, 1'b1, 1'b0, 1'b0, 16'd1, 1'b0, 2};
    vecs[14] = '{0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 2};

    // reset state
    tick();
    tick();
    chk_all_zero("rst");
    reset = 1'b1;
    tick();
    chk_all_zero("rst_rel");

`ifndef YCHG_RANGE_CHECK_EN
    // single record, done 5 cycles after start, batch end, clearing push, ISSUE-time dp_done
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].push_sel != 0) set_push(trecs[vecs[i].push_sel]);
      dp_done   = vecs[i].dp;
      batch_end = vecs[i].bend;
      tick();
      chg_push  = 1'b0;
      dp_done   = 1'b0;
      batch_end = 1'b0;
      chk1($sformatf("v%0d_start", i), chg_start, vecs[i].e_start);
      chk16($sformatf("v%0d_cnt", i), rec_count, vecs[i].e_cnt);
      chk1($sformatf("v%0d_bdone", i), batch_done, vecs[i].e_bdone);
      chkrec($sformatf("v%0d_data", i), trecs[vecs[i].e_sel]);
      chk1($sformatf("v%0d_full", i), chg_full, 1'b0);
      chk1($sformatf("v%0d_terr", i), timeout_err, 1'b0);
      chk1($sformatf("v%0d_derr", i), drop_err, 1'b0);
    end
`endif

    // three back-to-back records, done 3 cycles after each start, then batch end
    do_reset();
    for (int i = 0; i < 3; i++) rr[i] = mkrec(i + 1);
    set_push(rr[0]);
    tick();
    set_push(rr[1]);
    tick();
    chk1("t2_lat_start", chg_start, 1'b1);
    chkrec("t2_data0", rr[0]);
    set_push(rr[2]);
    tick();
    chg_push = 1'b0;
    chkrec("t2_hold0a", rr[0]);
    tick();
    chkrec("t2_hold0b", rr[0]);
    tick();
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    chk16("t2_cnt1", rec_count, 16'd1);
    for (int j = 1; j < 3; j++) begin
      wait_start(6, n, f);
      chk1($sformatf("t2_seen%0d", j), f, 1'b1);
      chkn($sformatf("t2_lat%0d", j), n, 1);
      chkrec($sformatf("t2_data%0d", j), rr[j]);
      tick();
      tick();
      tick();
      chkrec($sformatf("t2_hold%0d", j), rr[j]);
      dp_done = 1'b1;
      tick();
      dp_done = 1'b0;
    end
    chk16("t2_cnt3", rec_count, 16'd3);
    chk1("t2_bdone_pre", batch_done, 1'b0);
    batch_end = 1'b1;
    tick();
    batch_end = 1'b0;
    chk1("t2_bdone", batch_done, 1'b1);
    tick();
    chk1("t2_bdone_hold", batch_done, 1'b1);
    set_push(rr[0]);
    tick();
    chg_push = 1'b0;
    chk1("t2_bdone_clr", batch_done, 1'b0);
    chk16("t2_cnt_clr", rec_count, 16'd0);

    // watchdog expiry, then the queued record is issued
    do_reset();
    set_push(mkrec(30));
    tick();
    chg_push = 1'b0;
    wait_start(6, n, f);
    chk1("t3_seen", f, 1'b1);
    chkn("t3_lat", n, 1);
    set_push(mkrec(31));
    tick();
    chg_push = 1'b0;
    k = 1;
    while (rec_count == 16'd0 && k < 200) begin
      tick();
      k++;
    end
    chkn("t3_wait_len", k, TMO + 1);
    chk1("t3_terr", timeout_err, 1'b1);
    chk16("t3_cnt", rec_count, 16'd1);
    wait_start(6, n, f);
    chk1("t3_next_seen", f, 1'b1);
    chkn("t3_next_lat", n, 1);
    chkrec("t3_next_data", mkrec(31));
    serve_now();
    chk16("t3_cnt2", rec_count, 16'd2);
    chk1("t3_terr_sticky", timeout_err, 1'b1);

    // overflow: 8 pushes fill the FIFO while record X stalls; 9th lands on the pop cycle
    do_reset();
    set_push(mkrec(20));
    tick();
    chg_push = 1'b0;
    wait_start(6, n, f);
    chk1("t4_x_seen", f, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      set_push(mkrec(j));
      tick();
      if (j == 7) chk1("t4_notfull7", chg_full, 1'b0);
    end
    chg_push = 1'b0;
    chk1("t4_full8", chg_full, 1'b1);
    chk1("t4_derr_pre", drop_err, 1'b0);
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    chk16("t4_cnt_x", rec_count, 16'd1);
    chk1("t4_full_at_pop", chg_full, 1'b1);
    set_push(mkrec(9));
    tick();
    chg_push = 1'b0;
    chk1("t4_derr", drop_err, 1'b1);
    chk1("t4_full_after", chg_full, 1'b0);
    chk1("t4_start1", chg_start, 1'b1);
    chkrec("t4_data1", mkrec(1));
    serve_now();
    for (int j = 2; j <= 8; j++) begin
      wait_start(8, n, f);
      chk1($sformatf("t4_seen%0d", j), f, 1'b1);
      chkrec($sformatf("t4_data%0d", j), mkrec(j));
      serve_now();
    end
    wait_start(10, n, f);
    chk1("t4_no_ninth", f, 1'b0);
    chk16("t4_cnt", rec_count, 16'd9);

    // dp_done in the expiry cycle counts as done
    do_reset();
    set_push(mkrec(40));
    tick();
    chg_push = 1'b0;
    wait_start(6, n, f);
    chk1("t5_seen", f, 1'b1);
    repeat (TMO) tick();
    chk16("t5_cnt_pre", rec_count, 16'd0);
    dp_done = 1'b1;
    tick();
    dp_done = 1'b0;
    chk16("t5_cnt", rec_count, 16'd1);
    chk1("t5_terr", timeout_err, 1'b0);

    // asynchronous reset mid-WAIT
    set_push(mkrec(41));
    tick();
    chg_push = 1'b0;
    wait_start(6, n, f);
    chk1("t5r_seen", f, 1'b1);
    tick();
    tick();
    chkrec("t5r_data_pre", mkrec(41));
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("t5r_async");
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk16("t5r_cnt_after", rec_count, 16'd0);
    chk1("t5r_no_start", chg_start, 1'b0);

`ifdef YCHG_RANGE_CHECK_EN
    // out-of-range record discarded, following record issued
    do_reset();
    set_push('{16'h0000, 16'h0010, 24'h4ebd90, 24'h5c2e27});
    tick();
    set_push('{16'h0001, 16'h0002, 24'h000111, 24'hfff222});
    tick();
    chg_push = 1'b0;
    chk1("t6_derr", drop_err, 1'b1);
    chk1("t6_no_start_bad", chg_start, 1'b0);
    wait_start(6, n, f);
    chk1("t6_seen", f, 1'b1);
    chkn("t6_lat", n, 1);
    chkrec("t6_data", '{16'h0001, 16'h0002, 24'h000111, 24'hfff222});
    serve_now();
    chk16("t6_cnt", rec_count, 16'd1);
    wait_start(8, n, f);
    chk1("t6_no_more", f, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
